// File: rtl/rvvi_retire_sequencer_pkg.sv
// Shared types for the RVVI retire sequencer: one buffered retirement and a slot popcount helper.
package rvvi_seq_pkg;

   localparam int unsigned ILEN_MAX = 64;

   // insn is sized for the widest supported ILEN; narrower builds zero the upper bits
   typedef struct packed {
      logic [ILEN_MAX-1:0] insn;
      logic                trap;
      logic [63:0]         order;
   } retire_entry_t;

   function automatic int unsigned popcount_slots(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/rvvi_retire_sequencer_fifo.sv
// Per-hart FIFO: up to RETIRE pushes and one pop per cycle; excess pushes are dropped and flagged.
module rvvi_retire_fifo
   import rvvi_seq_pkg::*;
#(
   parameter int RETIRE = 1,
   parameter int DEPTH  = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [RETIRE-1:0]   push_valid,
   input  retire_entry_t       push_data [RETIRE],
   input  logic                pop,
   output retire_entry_t       head,
   output logic                empty,
   output logic [CW-1:0]       count,
   output logic                overflow
);

   retire_entry_t     mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [RETIRE-1:0] accept;
   logic [PW-1:0]     slot_off [RETIRE];
   logic [CW-1:0]     taken;
   logic              pop_ok;
   int unsigned       free_slots;

   assign empty  = (count == '0);
   assign pop_ok = pop && !empty;
   assign head   = mem[rd_ptr];

   // Valid slots are packed densely in ascending slot order; a same-cycle pop frees one entry.
   always_comb begin
      free_slots = 32'(DEPTH) - 32'(count) + 32'(pop_ok);
      taken      = '0;
      accept     = '0;
      for (int s = 0; s < RETIRE; s++) begin
         slot_off[s] = taken[PW-1:0];
         if (push_valid[s] && (32'(taken) < free_slots)) begin
            accept[s] = 1'b1;
            taken     = taken + CW'(1);
         end
      end
      overflow = popcount_slots(64'(push_valid)) > 32'(taken);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         wr_ptr <= wr_ptr + taken[PW-1:0];
         count  <= count + taken - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < RETIRE; s++) begin
         if (accept[s]) mem[wr_ptr + slot_off[s]] <= push_data[s];
      end
   end

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// Serializes multi-hart, multi-slot RVVI retirements into one in-order sample per cycle.
// Optional order-tag checking is enabled by defining RVVI_ORDER_CHECK_EN.
module rvvi_retire_sequencer
   import rvvi_seq_pkg::*;
#(
   parameter int ILEN   = 32,
   parameter int NHART  = 1,
   parameter int RETIRE = 1,
   parameter int DEPTH  = 8,
   localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NHART-1:0][RETIRE-1:0]              RetValid,
   input  logic [NHART-1:0][RETIRE-1:0][ILEN-1:0]    RetInsn,
   input  logic [NHART-1:0][RETIRE-1:0]              RetTrap,
   input  logic [NHART-1:0][RETIRE-1:0][63:0]        RetOrder,
   input  logic                                      SampleReady,
   output logic                                      SampleValid,
   output logic [HW-1:0]                             SampleHart,
   output logic [ILEN-1:0]                           SampleInsn,
   output logic                                      SampleTrap,
   output logic [63:0]                               SampleOrder,
   output logic                                      Overflow,
   output logic                                      OrderError
);

   logic [NHART-1:0]          empty;
   logic [NHART-1:0]          fifo_ovf;
   logic [NHART-1:0]          pop;
   logic [NHART-1:0][CW-1:0]  fifo_count;
   retire_entry_t             head [NHART];
   retire_entry_t             sel_entry;
   logic [HW-1:0]             last_hart;
   logic [HW-1:0]             hold_hart;
   logic [HW-1:0]             sel;
   logic                      hold_valid;
   logic                      any;
   logic                      fire;
   logic                      found;
   int                        idx;
   logic                      unused_sink;

   generate
      for (genvar h = 0; h < NHART; h++) begin : g_hart
         retire_entry_t push_data [RETIRE];

         always_comb begin
            for (int s = 0; s < RETIRE; s++) begin
               push_data[s]                = '0;
               push_data[s].insn[ILEN-1:0] = RetInsn[h][s];
               push_data[s].trap           = RetTrap[h][s];
               push_data[s].order          = RetOrder[h][s];
            end
         end

         assign pop[h] = fire && (sel == HW'(h));

         rvvi_retire_fifo #(
            .RETIRE (RETIRE),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_valid (RetValid[h]),
            .push_data  (push_data),
            .pop        (pop[h]),
            .head       (head[h]),
            .empty      (empty[h]),
            .count      (fifo_count[h]),
            .overflow   (fifo_ovf[h])
         );
      end
   endgenerate

   assign any  = |(~empty);
   assign fire = any && SampleReady;

   // A stalled choice is frozen so a newly non-empty higher-priority hart cannot steal the port.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      if (hold_valid) begin
         sel = hold_hart;
      end else begin
         for (int k = 1; k <= NHART; k++) begin
            idx = (int'(last_hart) + k) % NHART;
            if (!found && !empty[idx]) begin
               sel   = HW'(idx);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_entry   = head[sel];
      SampleValid = any;
      SampleHart  = any ? sel : '0;
      SampleInsn  = any ? sel_entry.insn[ILEN-1:0] : '0;
      SampleTrap  = any ? sel_entry.trap : 1'b0;
      SampleOrder = any ? sel_entry.order : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_hart  <= HW'(NHART - 1);
         hold_valid <= 1'b0;
         hold_hart  <= '0;
         Overflow   <= 1'b0;
      end else begin
         if (fire) begin
            last_hart  <= sel;
            hold_valid <= 1'b0;
         end else if (any) begin
            hold_valid <= 1'b1;
            hold_hart  <= sel;
         end
         if (|fifo_ovf) Overflow <= 1'b1;
      end
   end

`ifdef RVVI_ORDER_CHECK_EN
   logic [63:0]      exp_order [NHART];
   logic [NHART-1:0] exp_loaded;

   always_ff @(posedge clk) begin
      if (reset) begin
         exp_loaded <= '0;
         OrderError <= 1'b0;
      end else if (fire) begin
         if (exp_loaded[sel] && (SampleOrder != exp_order[sel] + 64'd1)) begin
            OrderError <= 1'b1;
            $error("rvvi order violation: hart %0d expected %0d actual %0d",
                   sel, exp_order[sel] + 64'd1, SampleOrder);
         end
         exp_loaded[sel] <= 1'b1;
         exp_order[sel]  <= SampleOrder;
      end
   end
`else
   assign OrderError = 1'b0;
`endif

   // Deliberately unused bits (fill counts, insn bits above ILEN) collected in one place.
   assign unused_sink = ^{fifo_count, sel_entry.insn};

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Directed bench for rvvi_retire_sequencer with two harts, two retire slots and 4-entry FIFOs.
module tb_rvvi_retire_sequencer;

   logic                   clk;
   logic                   reset;
   logic [1:0][1:0]        RetValid;
   logic [1:0][1:0][31:0]  RetInsn;
   logic [1:0][1:0]        RetTrap;
   logic [1:0][1:0][63:0]  RetOrder;
   logic                   SampleReady;
   logic                   SampleValid;
   logic [0:0]             SampleHart;
   logic [31:0]            SampleInsn;
   logic                   SampleTrap;
   logic [63:0]            SampleOrder;
   logic                   Overflow;
   logic                   OrderError;

   int checks = 0;
   int errors = 0;
   logic oe_exp;

   rvvi_retire_sequencer #(
      .ILEN   (32),
      .NHART  (2),
      .RETIRE (2),
      .DEPTH  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .RetValid    (RetValid),
      .RetInsn     (RetInsn),
      .RetTrap     (RetTrap),
      .RetOrder    (RetOrder),
      .SampleReady (SampleReady),
      .SampleValid (SampleValid),
      .SampleHart  (SampleHart),
      .SampleInsn  (SampleInsn),
      .SampleTrap  (SampleTrap),
      .SampleOrder (SampleOrder),
      .Overflow    (Overflow),
      .OrderError  (OrderError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      RetValid = '0;
      RetInsn  = '0;
      RetTrap  = '0;
      RetOrder = '0;
   endtask

   // Trap flag follows insn bit 0 so each sample carries a predictable trap value.
   task automatic ret(input int h, input int s, input logic [31:0] insn, input logic [63:0] ord);
      RetValid[h][s] = 1'b1;
      RetInsn[h][s]  = insn;
      RetTrap[h][s]  = insn[0];
      RetOrder[h][s] = ord;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      SampleReady = 1'b0;
      clr();
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", SampleValid, 0);
      chk("rst_hart", SampleHart, 0);
      chk("rst_insn", SampleInsn, 0);
      chk("rst_order", SampleOrder, 0);
      chk("rst_overflow", Overflow, 0);
      chk("rst_ordererr", OrderError, 0);

      // single hart, single slot, back-to-back
      SampleReady = 1'b1;
      ret(0, 0, 32'h0000_0013, 0);
      #1;
      chk("no_bypass", SampleValid, 0);
      tick();
      chk("t1_valid0", SampleValid, 1);
      chk("t1_insn0", SampleInsn, 32'h0000_0013);
      chk("t1_hart0", SampleHart, 0);
      chk("t1_trap0", SampleTrap, 1);
      clr();
      ret(0, 0, 32'h0010_0093, 1);
      tick();
      chk("t1_valid1", SampleValid, 1);
      chk("t1_insn1", SampleInsn, 32'h0010_0093);
      chk("t1_order1", SampleOrder, 1);
      clr();
      tick();
      chk("t1_drained", SampleValid, 0);
      chk("t1_overflow", Overflow, 0);

      // two harts retiring together: round-robin alternation
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         clr();
         if (k < 4) begin
            ret(0, 0, 32'hA0 + 32'(k), 64'(k));
            ret(1, 0, 32'hB0 + 32'(k), 64'(k));
         end
         tick();
         chk("t2_valid", SampleValid, 1);
         chk("t2_hart", SampleHart, 64'(k % 2));
         chk("t2_insn", SampleInsn, ((k % 2) != 0 ? 32'hB0 : 32'hA0) + 32'(k / 2));
         chk("t2_order", SampleOrder, 64'(k / 2));
      end
      clr();
      tick();
      chk("t2_drained", SampleValid, 0);
      chk("t2_overflow", Overflow, 0);

      // dual retire into a stalled 4-deep FIFO: third cycle overflows
      SampleReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         clr();
         ret(0, 0, 32'hC0 + 32'(2 * c), 64'(4 + 2 * c));
         ret(0, 1, 32'hC1 + 32'(2 * c), 64'(5 + 2 * c));
         tick();
         chk("t3_overflow", Overflow, (c == 2) ? 1 : 0);
         chk("t3_stall_insn", SampleInsn, 32'hC0);
         chk("t3_stall_valid", SampleValid, 1);
      end
      clr();
      SampleReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t3_insn", SampleInsn, 32'hC0 + 32'(k));
         chk("t3_order", SampleOrder, 64'(4 + k));
         chk("t3_trap", SampleTrap, 64'(k % 2));
         tick();
      end
      chk("t3_drained", SampleValid, 0);
      chk("t3_overflow_sticky", Overflow, 1);

      // full FIFO with simultaneous pop and two pushes
      pulse_reset();
      chk("t4_rst_overflow", Overflow, 0);
      SampleReady = 1'b0;
      clr();
      ret(0, 0, 32'hD0, 0);
      ret(0, 1, 32'hD1, 1);
      tick();
      clr();
      ret(0, 0, 32'hD2, 2);
      ret(0, 1, 32'hD3, 3);
      tick();
      chk("t4_full_overflow", Overflow, 0);
      chk("t4_full_head", SampleInsn, 32'hD0);
      SampleReady = 1'b1;
      clr();
      ret(0, 0, 32'hD4, 4);
      ret(0, 1, 32'hD5, 5);
      tick();
      chk("t4_overflow", Overflow, 1);
      clr();
      for (int k = 1; k < 5; k++) begin
         chk("t4_insn", SampleInsn, 32'hD0 + 32'(k));
         chk("t4_valid", SampleValid, 1);
         tick();
      end
      chk("t4_drained", SampleValid, 0);

      // reset with three entries buffered, retirements held during reset
      SampleReady = 1'b0;
      clr();
      ret(1, 0, 32'hE0, 0);
      ret(1, 1, 32'hE1, 1);
      ret(0, 0, 32'hE2, 0);
      tick();
      chk("t5_pre_hart", SampleHart, 1);
      chk("t5_pre_insn", SampleInsn, 32'hE0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clr();
      chk("t5_valid", SampleValid, 0);
      chk("t5_overflow", Overflow, 0);
      chk("t5_insn", SampleInsn, 0);
      chk("t5_hart", SampleHart, 0);
      SampleReady = 1'b1;
      ret(0, 0, 32'hF0, 0);
      ret(1, 0, 32'hF1, 0);
      tick();
      clr();
      chk("t5_first_hart", SampleHart, 0);
      chk("t5_first_insn", SampleInsn, 32'hF0);
      tick();
      chk("t5_second_hart", SampleHart, 1);
      chk("t5_second_insn", SampleInsn, 32'hF1);
      tick();
      chk("t5_drained", SampleValid, 0);

      // order tags 5, 6, 8 on hart 0
`ifdef RVVI_ORDER_CHECK_EN
      oe_exp = 1'b1;
`else
      oe_exp = 1'b0;
`endif
      pulse_reset();
      SampleReady = 1'b1;
      clr();
      ret(0, 0, 32'h5, 5);
      tick();
      clr();
      ret(0, 0, 32'h6, 6);
      tick();
      chk("t6_ordererr_early", OrderError, 0);
      clr();
      ret(0, 0, 32'h8, 8);
      tick();
      chk("t6_ordererr_mid", OrderError, 0);
      chk("t6_order_head", SampleOrder, 8);
      clr();
      tick();
      chk("t6_ordererr", OrderError, oe_exp);
      tick();
      chk("t6_ordererr_sticky", OrderError, oe_exp);
      chk("t6_drained", SampleValid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
